// File: rtl/inv_quan_pkg.sv
// Shared definitions for the inverse quantiser stream block.
// Contents:
//   DEFAULT_TBL   - reconstruction levels for the 4-bit code / 16-bit level configuration
//   default_level - reset value for table entry i at any CODE_W/OUT_W; configurations
//                   other than 4/16 fall back to a linear ramp (i << (OUT_W-CODE_W))
package inv_quan_pkg;

  localparam int DEF_CODE_W = 4;
  localparam int DEF_OUT_W  = 16;

  localparam logic [15:0] DEFAULT_TBL [16] = '{
    16'h0000, 16'h3AF9, 16'h51A8, 16'h6069, 16'h6BD7, 16'h74F2, 16'h7B04, 16'h7E7F,
    16'h7FF7, 16'h8179, 16'h851C, 16'h8B7B, 16'h9511, 16'hA195, 16'hB2CE, 16'hC7CA
  };

  // Returns a 64-bit value; callers truncate it to OUT_W.
  function automatic logic [63:0] default_level(input int i, input int code_w, input int out_w);
    logic [3:0] idx;
    idx = i[3:0];
    if (code_w == DEF_CODE_W && out_w == DEF_OUT_W)
      return {48'd0, DEFAULT_TBL[idx]};
    return 64'(i) << (out_w - code_w);
  endfunction

endpackage

// File: rtl/inv_quan_tbl.sv
// One channel's reconstruction level table: 2**CODE_W entries of OUT_W bits.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (reloads the defaults)
//   i_we            - write strobe; the entry changes at this rising edge
//   i_waddr/i_wdata - write entry and data
//   i_raddr         - asynchronous read address
//   o_rdata         - read data; shows the pre-write value during a write cycle
module inv_quan_tbl
  import inv_quan_pkg::*;
#(
  parameter int CODE_W = 4,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [CODE_W-1:0] i_waddr,
  input  logic [OUT_W-1:0]  i_wdata,
  input  logic [CODE_W-1:0] i_raddr,
  output logic [OUT_W-1:0]  o_rdata
);

  localparam int DEPTH = 2 ** CODE_W;

  logic [OUT_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= OUT_W'(default_level(i, CODE_W, OUT_W));
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inv_quan_stream.sv
// Pipelined, multi-channel inverse quantiser with a valid/ready stream interface.
// Maps each CODE_W-bit code to an OUT_W-bit level taken from a per-channel table.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   in_valid/in_ready             - input handshake
//   in_code/in_ch/in_signed       - code, channel, two's-complement output select
//   out_valid/out_ready           - output handshake
//   out_level/out_ch              - reconstruction level and its channel
//   tbl_we/tbl_ch/tbl_addr/tbl_wdata - runtime table write port
//   illegal_ch                    - sticky flag: an out-of-range channel was seen
// Pipeline: S1 holds the accepted beat, the table lookup happens on the S1->S2
// transfer, and S2 drives the outputs. Latency is 2 cycles, throughput 1 beat/cycle.
module inv_quan_stream
  import inv_quan_pkg::*;
#(
  parameter int CODE_W = 4,
  parameter int OUT_W  = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_level,
  output logic [CH_W-1:0]   out_ch,
  input  logic              tbl_we,
  input  logic [CH_W-1:0]   tbl_ch,
  input  logic [CODE_W-1:0] tbl_addr,
  input  logic [OUT_W-1:0]  tbl_wdata,
  output logic              illegal_ch
);

  // One extra bit so NUM_CH == 2**CH_W is representable in the range compare.
  localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [CH_W-1:0]   r_s1_ch;
  logic              r_s1_signed;
  logic              r_s2_valid;
  logic [OUT_W-1:0]  r_s2_level;
  logic [CH_W-1:0]   r_s2_ch;
  logic              r_illegal;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_in_ill;
  logic              w_tbl_ill;
  logic              w_s1_ill;
  logic [OUT_W-1:0]  w_rd [NUM_CH];
  logic [OUT_W-1:0]  w_level;
  logic [OUT_W-1:0]  w_s2_level_d;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_in_ill  = {1'b0, in_ch}   >= NUM_CH_X;
  assign w_tbl_ill = {1'b0, tbl_ch}  >= NUM_CH_X;
  assign w_s1_ill  = {1'b0, r_s1_ch} >= NUM_CH_X;

  // Out-of-range channels match no table and therefore never get written.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tbl
    logic w_we;
    assign w_we = tbl_we & (tbl_ch == CH_W'(g));

    inv_quan_tbl #(
      .CODE_W (CODE_W),
      .OUT_W  (OUT_W)
    ) u_tbl (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_waddr (tbl_addr),
      .i_wdata (tbl_wdata),
      .i_raddr (r_s1_code),
      .o_rdata (w_rd[g])
    );
  end

  always_comb begin
    w_level = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_s1_ch == CH_W'(c))
        w_level = w_rd[c];
    end
  end

  // An illegal channel yields exactly zero; the sign inversion applies to real levels only.
  assign w_s2_level_d = w_s1_ill ? '0 : (w_level ^ {r_s1_signed, {(OUT_W-1){1'b0}}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_code   <= '0;
      r_s1_ch     <= '0;
      r_s1_signed <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_level  <= '0;
      r_s2_ch     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_code   <= in_code;
          r_s1_ch     <= in_ch;
          r_s1_signed <= in_signed;
        end
      end
      // S2 data only moves when a new beat arrives, so it holds while stalled.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_level <= w_s2_level_d;
          r_s2_ch    <= r_s1_ch;
        end
      end
      if ((in_valid & w_s1_adv & w_in_ill) | (tbl_we & w_tbl_ill))
        r_illegal <= 1'b1;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_level  = r_s2_level;
  assign out_ch     = r_s2_ch;
  assign illegal_ch = r_illegal;

endmodule

// File: tb/tb_inv_quan_stream.sv
module tb_inv_quan_stream;

  localparam int CODE_W = 4;
  localparam int OUT_W  = 16;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [CH_W-1:0]   in_ch;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_level;
  logic [CH_W-1:0]   out_ch;
  logic              tbl_we;
  logic [CH_W-1:0]   tbl_ch;
  logic [CODE_W-1:0] tbl_addr;
  logic [OUT_W-1:0]  tbl_wdata;
  logic              illegal_ch;

  always #5 clk = ~clk;

  inv_quan_stream #(
    .CODE_W (CODE_W),
    .OUT_W  (OUT_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_ch      (in_ch),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_level  (out_level),
    .out_ch     (out_ch),
    .tbl_we     (tbl_we),
    .tbl_ch     (tbl_ch),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .illegal_ch (illegal_ch)
  );

  typedef struct {
    logic [15:0] level;
    logic [1:0]  ch;
    int          cyc;
  } exp_t;

  localparam logic [15:0] DEFS [16] = '{
    16'h0000, 16'h3AF9, 16'h51A8, 16'h6069, 16'h6BD7, 16'h74F2, 16'h7B04, 16'h7E7F,
    16'h7FF7, 16'h8179, 16'h851C, 16'h8B7B, 16'h9511, 16'hA195, 16'hB2CE, 16'hC7CA
  };

  exp_t        sb[$];
  logic [15:0] model [NUM_CH][16];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          chk_lat = 0;
  bit          rnd_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void load_defaults();
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < 16; i++)
        model[c][i] = DEFS[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a beat accepted at an edge sees every legal table write made at
  // or before that edge (bench only writes with no stall in progress).
  initial begin : recorder
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        load_defaults();
      end else begin
        if (tbl_we && int'(tbl_ch) < NUM_CH)
          model[tbl_ch][tbl_addr] = tbl_wdata;
        if (in_valid && in_ready) begin
          e.ch  = in_ch;
          e.cyc = cyc;
          if (int'(in_ch) >= NUM_CH) e.level = 16'h0000;
          else e.level = model[in_ch][in_code] ^ (in_signed ? 16'h8000 : 16'h0000);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got level %h ch %0d, expected no beat", out_level, out_ch);
        end else begin
          e = sb.pop_front();
          check("out_level", 32'(out_level), 32'(e.level));
          check("out_ch", 32'(out_ch), 32'(e.ch));
          if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [3:0] c, input logic [1:0] ch, input logic s);
    int n;
    bit ok;
    in_valid  = 1'b1;
    in_code   = c;
    in_ch     = ch;
    in_signed = s;
    n  = 0;
    ok = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic tbl_write(input logic [1:0] ch, input logic [3:0] a, input logic [15:0] d);
    tbl_we    = 1'b1;
    tbl_ch    = ch;
    tbl_addr  = a;
    tbl_wdata = d;
    @(posedge clk);
    #1;
    tbl_we = 1'b0;
  endtask

  initial begin : main
    int          idx;
    bit          held_v;
    logic [15:0] held_lvl;
    logic [1:0]  rch;

    reset = 1'b1; in_valid = 1'b0; in_code = '0; in_ch = '0; in_signed = 1'b0;
    out_ready = 1'b1; tbl_we = 1'b0; tbl_ch = '0; tbl_addr = '0; tbl_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_level", 32'(out_level), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_illegal", 32'(illegal_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // defaults, back-to-back, fixed latency
    chk_lat = 1;
    for (int i = 0; i < 16; i++) send(4'(i), 2'd0, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_lat = 0;

    // signed mode: 8000 then 47CA
    send(4'd0, 2'd0, 1'b1);
    send(4'd15, 2'd0, 1'b1);
    in_valid = 1'b0;
    drain();

    // backpressure
    out_ready = 1'b0;
    idx = 0;
    held_v = 0;
    held_lvl = '0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_ch = 2'd1; in_signed = 1'b0; in_code = 4'(idx + 1);
      @(negedge clk);
      if (in_ready) idx++;
      if (out_valid) begin
        if (!held_v) begin
          held_lvl = out_level;
          held_v = 1;
        end else check("hold_level", 32'(out_level), 32'(held_lvl));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    while (idx < 6) begin
      send(4'(idx + 1), 2'd1, 1'b0);
      idx++;
    end
    in_valid = 1'b0;
    drain();

    // write during S1 residency: old, then new, other channel unaffected
    send(4'd3, 2'd1, 1'b0);
    in_valid = 1'b0;
    tbl_write(2'd1, 4'd3, 16'h1234);
    send(4'd3, 2'd1, 1'b0);
    send(4'd3, 2'd0, 1'b0);
    in_valid = 1'b0;
    drain();

    // illegal channel
    send(4'd7, 2'd3, 1'b0);
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("illegal_set", 32'(illegal_ch), 32'd1);
    @(posedge clk);
    #1;

    // randomized traffic with random backpressure; table writes only when drained
    rnd_en = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      rch = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(4'($urandom_range(0, 15)), rch, (rch == 2'd3) ? 1'b0 : 1'($urandom_range(0, 1)));
      if (n % 50 == 49) begin
        in_valid = 1'b0;
        rnd_en = 0;
        out_ready = 1'b1;
        drain();
        tbl_write(2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 16'($urandom));
        rnd_en = 1;
      end
    end
    in_valid = 1'b0;
    rnd_en = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    check("illegal_sticky", 32'(illegal_ch), 32'd1);
    @(posedge clk);
    #1;

    // reset with two beats in flight after a write
    tbl_write(2'd0, 4'd5, 16'hABCD);
    send(4'd5, 2'd0, 1'b0);
    in_valid = 1'b0;
    drain();
    send(4'd5, 2'd0, 1'b0);
    send(4'd1, 2'd1, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_illegal", 32'(illegal_ch), 32'd0);
    @(posedge clk);
    #1;
    send(4'd5, 2'd0, 1'b0);
    in_valid = 1'b0;
    drain();

    // illegal table write: ignored, flag set
    tbl_write(2'd3, 4'd2, 16'hFFFF);
    @(negedge clk);
    check("illegal_tbl_write", 32'(illegal_ch), 32'd1);
    @(posedge clk);
    #1;
    send(4'd2, 2'd0, 1'b0);
    send(4'd2, 2'd2, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
